gonso_stepper_ctrl: RTL and testbench



---
 rtl/gonso_stepper_pkg.sv | 28 ++
 rtl/gonso_stepper_ctrl_if.sv | 21 ++
 rtl/gonso_stepper_seq.sv | 98 +++++++++
 rtl/gonso_stepper_ctrl.sv | 117 +++++++++++
 tb/tb_gonso_stepper_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/gonso_stepper_pkg.sv
// Shared constants for the gonso stepper sequencer: register map, CTRL bit
// positions, sequencer state encoding and the coil phase table.
package gonso_stepper_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STEPS  = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_HALF  = 2;
  localparam int CTRL_ABORT = 3;
  localparam int CTRL_HOLD  = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seq_state_e;

  // Odd entries energise two coils, even entries one coil.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [3:0] phase(input logic [2:0] idx);
    return PHASE_TBL[idx];
  endfunction

endpackage

// File: rtl/gonso_stepper_ctrl_if.sv
// Wishbone slave bundle shared by the gonso core and the stepper register window.
interface gonso_stepper_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wishbone_address;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wishbone_address, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wishbone_address, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/gonso_stepper_seq.sv
// Step sequencer: period countdown, remaining-step counter, phase index, sticky
// completion flags and the registered coil drive.
module gonso_stepper_seq
  import gonso_stepper_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             clr_i,
  input  logic             dir_i,
  input  logic             half_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic [3:0]       motor_o
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, rem_q, rem_d, period_eff;
  logic [2:0]       idx_q, idx_d, delta;
  logic             done_q, done_d, aborted_q, aborted_d;
  logic [3:0]       motor_q, motor_d;

  // PERIOD is sampled at every reload so a busy-time write lands on the next step.
  assign period_eff = (period_i == '0) ? CNT_W'(1) : period_i;
  assign delta      = half_i ? 3'd1 : 3'd2;

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    done_d    = done_q & ~clr_i;
    aborted_d = aborted_q & ~clr_i;
    if (state_q == IDLE) begin
      if (start_i && !abort_i) begin
        if (steps_i == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = RUN;
          rem_d   = steps_i;
          pcnt_d  = period_eff;
          if (!half_i) idx_d = idx_q | 3'd1;
        end
      end
    end else begin
      if (abort_i) begin
        state_d   = IDLE;
        aborted_d = 1'b1;
      end else if (pcnt_q == CNT_W'(1)) begin
        idx_d  = dir_i ? idx_q + delta : idx_q - delta;
        rem_d  = rem_q - CNT_W'(1);
        pcnt_d = period_eff;
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        pcnt_d = pcnt_q - CNT_W'(1);
      end
    end
    motor_d = (state_d == RUN || hold_i) ? phase(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      motor_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      motor_q   <= motor_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign remaining_o = rem_q;
  assign motor_o     = motor_q;

endmodule

// File: rtl/gonso_stepper_ctrl.sv
// Wishbone register window (CTRL/STEPS/PERIOD/STATUS) for the gonso stepper
// driver; the step sequencing itself lives in gonso_stepper_seq.
module gonso_stepper_ctrl
  import gonso_stepper_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR  = 32'h3000_0100,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(1000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gonso_stepper_ctrl_if.slave  wb,
  output logic [3:0]           motor_out,
  output logic                 busy,
  output logic                 irq_done
);

  logic             hit, acc, wr, rd;
  logic [1:0]       off;
  logic             ack_q;
  logic [31:0]      dat_q, rdata;
  logic             dir_q, half_q, hold_q, dir_d, half_d, hold_d;
  logic [CNT_W-1:0] steps_q, steps_d, period_q, period_d, remaining;
  logic             start, abort, clr, done, aborted;
  logic             unused_ok;

  assign hit = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wishbone_address[31:4] == BASE_ADDR[31:4]);
  // Blocking a back-to-back ack makes every access exactly two cycles.
  assign acc = hit & ~ack_q;
  assign wr  = acc & wb.wbs_we_i;
  assign rd  = acc & ~wb.wbs_we_i;
  assign off = wb.wishbone_address[3:2];

  assign start = wr && off == OFF_CTRL && wb.wbs_dat_i[CTRL_START];
  assign abort = wr && off == OFF_CTRL && wb.wbs_dat_i[CTRL_ABORT];
  assign clr   = rd && off == OFF_STATUS;

  always_comb begin
    dir_d    = dir_q;
    half_d   = half_q;
    hold_d   = hold_q;
    steps_d  = steps_q;
    period_d = period_q;
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          dir_d  = wb.wbs_dat_i[CTRL_DIR];
          half_d = wb.wbs_dat_i[CTRL_HALF];
          hold_d = wb.wbs_dat_i[CTRL_HOLD];
        end
        OFF_STEPS:  if (!busy) steps_d = wb.wbs_dat_i[CNT_W-1:0];
        OFF_PERIOD: period_d = wb.wbs_dat_i[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_DIR]  = dir_q;
        rdata[CTRL_HALF] = half_q;
        rdata[CTRL_HOLD] = hold_q;
      end
      OFF_STEPS:  rdata = 32'(steps_q);
      OFF_PERIOD: rdata = 32'(period_q);
      default:    rdata = {16'(remaining), 13'd0, aborted, done, busy};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      hold_q   <= 1'b0;
      steps_q  <= '0;
      period_q <= PERIOD_RST;
    end else begin
      ack_q    <= acc;
      dat_q    <= rd ? rdata : '0;
      dir_q    <= dir_d;
      half_q   <= half_d;
      hold_q   <= hold_d;
      steps_q  <= steps_d;
      period_q <= period_d;
    end
  end

  // The sequencer sees the CTRL value being written so START picks up DIR/HALF/HOLD
  // from the same access.
  gonso_stepper_seq #(.CNT_W(CNT_W)) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .clr_i       (clr),
    .dir_i       (dir_d),
    .half_i      (half_d),
    .hold_i      (hold_d),
    .steps_i     (steps_q),
    .period_i    (period_q),
    .busy_o      (busy),
    .done_o      (done),
    .aborted_o   (aborted),
    .remaining_o (remaining),
    .motor_o     (motor_out)
  );

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign irq_done     = done;
  assign unused_ok    = ^{wb.wbs_sel_i, wb.wishbone_address[1:0], wb.wbs_dat_i};

endmodule

// File: tb/tb_gonso_stepper_ctrl.sv
// Directed + randomized bench for gonso_stepper_ctrl with a step-count model.
module tb_gonso_stepper_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gonso_stepper_ctrl_if wb();
  logic [3:0] motor_out;
  logic       busy, irq_done;

  gonso_stepper_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb),
    .motor_out (motor_out),
    .busy      (busy),
    .irq_done  (irq_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int m_idx = 0;
  logic [3:0] tbl [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h4, 4'hC, 4'h8, 4'h9};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input bit we, input logic [1:0] off, input logic [31:0] wd,
                     output logic [31:0] rdv, output int t);
    bit got = 0;
    rdv = 'x;
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we; wb.wbs_sel_i = 4'hf;
    wb.wishbone_address = BASE + {28'd0, off, 2'b00}; wb.wbs_dat_i = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) begin got = 1; rdv = wb.wbs_dat_o; end
    end
    t = cyc;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] wd, output int t);
    logic [31:0] d;
    acc(1'b1, off, wd, d, t);
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    int t;
    acc(1'b0, off, 32'd0, d, t);
  endtask

  function automatic int wrap8(input int x);
    return ((x % 8) + 8) % 8;
  endfunction

  // Expected state after c cycles from the START ack: k = floor(c/P) steps taken.
  task automatic run_move(input int P, input int N, input bit dir, input bit half, input bit hold);
    int t0, t, pe, idx0, stp, k, c;
    logic [31:0] d;
    pe   = (P == 0) ? 1 : P;
    stp  = (half ? 1 : 2) * (dir ? 1 : -1);
    wr(2'd2, 32'(P), t);
    wr(2'd1, 32'(N), t);
    idx0 = half ? m_idx : (m_idx | 1);
    wr(2'd0, {27'd0, hold, 1'b0, half, dir, 1'b1}, t0);
    for (int i = 0; i <= pe * N + 2; i++) begin
      c = cyc - t0;
      k = c / pe;
      if (k > N) k = N;
      chk("motor", 32'(motor_out),
          32'((k < N || hold) ? tbl[wrap8(idx0 + stp * k)] : 4'h0));
      chk("busy", 32'(busy), 32'(k < N));
      @(negedge clk);
    end
    m_idx = wrap8(idx0 + stp * N);
    chk("irq_set", 32'(irq_done), 32'd1);
    rd(2'd3, d);
    chk("status_done", d, 32'h2);
    chk("irq_clr", 32'(irq_done), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int t, t0, ta, s, rem;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0; wb.wbs_sel_i = 0;
    wb.wishbone_address = 0; wb.wbs_dat_i = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_motor", 32'(motor_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq_done), 32'd0);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    rst_n = 1'b1;

    // Held strobe: ack pulses 1,0,1,0
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0;
    wb.wishbone_address = BASE + 32'h8;
    @(negedge clk); chk("ack_p1", 32'(wb.wbs_ack_o), 32'd1); chk("period_rst", wb.wbs_dat_o, 32'd1000);
    @(negedge clk); chk("ack_p2", 32'(wb.wbs_ack_o), 32'd0); chk("dat_idle", wb.wbs_dat_o, 32'd0);
    @(negedge clk); chk("ack_p3", 32'(wb.wbs_ack_o), 32'd1);
    @(negedge clk); chk("ack_p4", 32'(wb.wbs_ack_o), 32'd0);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    rd(2'd3, d); chk("rst_status", d, 32'd0);
    rd(2'd0, d); chk("rst_ctrl", d, 32'd0);
    rd(2'd1, d); chk("rst_steps", d, 32'd0);

    // Full step forward with hold, then half-step moves
    run_move(4, 3, 1'b1, 1'b0, 1'b1);
    rd(2'd0, d); chk("ctrl_rb", d, 32'h12);
    run_move(1, 2, 1'b1, 1'b1, 1'b1);
    run_move(2, 4, 1'b0, 1'b1, 1'b0);

    // START with STEPS=0
    wr(2'd1, 32'd0, t);
    wr(2'd0, 32'h01, t);
    chk("zero_irq", 32'(irq_done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    rd(2'd3, d); chk("zero_status", d, 32'h2);

    // PERIOD=0 behaves as 1
    wr(2'd2, 32'd0, t);
    rd(2'd2, d); chk("period0_rb", d, 32'd0);
    run_move(0, 2, 1'b1, 1'b1, 1'b1);

    // Random moves
    for (int i = 0; i < 6; i++)
      run_move($urandom_range(1, 5), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Outside the window: no ack
    @(negedge clk);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wishbone_address = BASE + 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("oow_ack", 32'(wb.wbs_ack_o), 32'd0);
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;

    // Long move, STEPS write while busy, then ABORT
    wr(2'd2, 32'd10, t);
    wr(2'd1, 32'd100, t);
    wr(2'd0, 32'h03, t0);
    chk("abort_busy0", 32'(busy), 32'd1);
    wr(2'd1, 32'd7, t);
    rd(2'd1, d); chk("steps_locked", d, 32'd100);
    for (int i = 0; i < 100 && cyc < t0 + 33; i++) @(negedge clk);
    wr(2'd0, 32'h0A, ta);
    s = (ta - t0 - 1) / 10;
    if (s > 100) s = 100;
    rem = 100 - s;
    m_idx = wrap8((m_idx | 1) + 2 * s);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_irq", 32'(irq_done), 32'd0);
    @(negedge clk);
    chk("abort_motor", 32'(motor_out), 32'd0);
    rd(2'd3, d); chk("abort_status", d, (32'(rem) << 16) | 32'h4);
    rd(2'd3, d); chk("abort_clr", d, 32'(rem) << 16);
    wr(2'd0, 32'h08, t);
    wr(2'd0, 32'h09, t);
    chk("startabort_busy", 32'(busy), 32'd0);
    rd(2'd3, d); chk("idle_abort", d, 32'(rem) << 16);
    rd(2'd1, d); chk("steps_keep", d, 32'd100);

    // Async reset mid-move
    wr(2'd2, 32'd3, t);
    wr(2'd1, 32'd50, t);
    wr(2'd0, 32'h17, t);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_motor", 32'(motor_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0;
    rd(2'd2, d); chk("rerst_period", d, 32'd1000);
    rd(2'd1, d); chk("rerst_steps", d, 32'd0);
    run_move(1, 1, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
